trace_trigger_seq: RTL and testbench
====================================

# trace_trigger_seq

Trigger sequencer placed directly downstream of `trace_trigger` in the TRACECLK domain. It consumes the per-rule match pulses on `O_matching_pattern`, counts qualifying matches while armed, then applies a programmable delay. After the delay it emits a trigger pulse of programmable width toward the capture hardware. Configuration comes from `reg_trace` and is resynchronised upstream of this block.

## Interface

Parameters:
- `pMATCH_RULES`, 8: number of match rules; width of the match and select vectors.
- `pCOUNT_WIDTH`, 16: width of the match-count threshold and of the match total.
- `pDELAY_WIDTH`, 16: width of the post-match delay.
- `pWIDTH_WIDTH`, 8: width of the trigger pulse-width setting.

Ports:
- `TRACECLK`, in, 1: sole clock; all logic is clocked on the rising edge.
- `resetn`, in, 1: reset, synchronous, active-low.
- `I_matching_pattern`, in, `pMATCH_RULES`: one-cycle pulse per rule on a match.
- `I_rule_select`, in, `pMATCH_RULES`: rules that qualify a match; OR-combined.
- `I_match_count`, in, `pCOUNT_WIDTH`: qualifying matches required; 0 is treated as 1.
- `I_delay`, in, `pDELAY_WIDTH`: cycles from the final qualifying match to trigger assertion; 0 means minimum latency.
- `I_pulse_width`, in, `pWIDTH_WIDTH`: trigger high time in cycles; 0 is treated as 1.
- `I_arm`, in, 1: single-cycle arm request.
- `I_disarm`, in, 1: single-cycle abort request.
- `O_trig_out`, out, 1: registered trigger pulse.
- `O_armed`, out, 1: high while in ARMED.
- `O_done`, out, 1: sequence complete (see Configuration).
- `O_match_total`, out, `pCOUNT_WIDTH`: qualifying matches seen while in ARMED; saturates at all-ones.

## Operation

- **Qualifying event:** `q = |(I_matching_pattern & sel_l)`, where `sel_l` is the latched rule select.
- **Configuration latch:** `I_rule_select`, `I_match_count`, `I_delay` and `I_pulse_width` are captured on an accepted `I_arm`. Later input changes have no effect until the next arm.
- **States:** IDLE, ARMED, DELAY, PULSE, DONE.
- **IDLE:**
  - On `I_arm`, go to ARMED.
  - Clear the match counter and `O_match_total`.
- **ARMED:**
  - On `q`, increment the counter and `O_match_total` (saturating).
  - If the new counter value is at least the effective threshold:
    - go to PULSE when the latched delay is 0;
    - otherwise load the delay counter and go to DELAY.
  - Multiple bits of `I_matching_pattern` set in one cycle count as one match.
- **DELAY:**
  - Decrement the delay counter every cycle.
  - Go to PULSE on the cycle in which the counter reaches 0.
  - Matches are ignored.
- **PULSE:**
  - `O_trig_out` = 1; the width counter runs.
  - Exit after the effective width has elapsed. The exit target is given in Configuration.
  - Matches are ignored.
- **DONE:**
  - `O_done` = 1.
  - `I_arm` goes to ARMED with counters cleared, exactly as from IDLE.
- **Disarm:**
  - `I_disarm` in any state forces IDLE on the next edge.
  - `O_trig_out`, `O_armed` and `O_done` drop with that edge; `O_match_total` is held.
- **Arm and disarm in the same cycle:** disarm wins.
- **Arm in ARMED, DELAY or PULSE:** ignored.

## Timing

- **Reset values:** when `resetn` is sampled low, state = IDLE. `O_trig_out`, `O_armed`, `O_done` and `O_match_total` are all 0, and all internal counters are 0.
- **Arm latency:** with `I_arm` sampled at edge k, `O_armed` is high from edge k. A match sampled at edge k+1 is the first that can count.
- **Trigger latency:** with the final qualifying match sampled at edge N, `O_trig_out` rises at edge N+1+D, where D is the latched delay. It stays high for exactly W cycles, where W is the effective width.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Counter sizing:**
  - Delay counter width = `pDELAY_WIDTH`, so the maximum delay is 2^pDELAY_WIDTH−1.
  - Width counter width = `pWIDTH_WIDTH`.
  - Neither counter wraps.
- **Match-count saturation:** `O_match_total` saturates at all-ones. The threshold comparison uses the saturated value, which remains valid because the threshold is at most all-ones.

## Configuration

- **Macro:** `TRACE_TRIG_SEQ_AUTOREARM_EN`.
- **Defined:**
  - When PULSE completes, go directly to ARMED with the match counter cleared; `O_match_total` keeps accumulating.
  - `O_done` pulses high for one cycle on that transition.
  - DONE is unreachable.
- **Undefined:**
  - When PULSE completes, go to DONE.
  - `O_done` stays high until `I_arm` or `I_disarm`.
  - `O_armed` = 0 while in DONE.

## Test plan

- **Reset, basic trigger:**
  - Stimulus: reset held low 3 cycles; arm with select=0x01, count=1, delay=0, width=1; pulse rule 0 at edge 10.
  - Required: `O_trig_out` high for exactly edge 11; `O_done`=1 from edge 12; `O_match_total`=1.
- **Count, select and delay:**
  - Stimulus: select=0x0C, count=3, delay=5, width=4. Pulse rule 2 once and rule 3 once; then rules 2 and 3 together (final match at edge N); also pulse rule 0 several times.
  - Required: rule 0 ignored; the dual-rule cycle counts as one match; `O_trig_out` high for edges N+6 to N+9.
- **Disarm and arm collision:**
  - Stimulus: `I_disarm` during DELAY; separately, `I_arm` and `I_disarm` asserted in the same cycle while in IDLE.
  - Required: no trigger from the first case; state remains IDLE with `O_armed`=0 in both cases.
- **Zero-value settings:**
  - Stimulus: count=0, width=0.
  - Required: the first qualifying match triggers a 1-cycle pulse.
- **Saturation and latched configuration:**
  - Stimulus: count=0xFFFF, more than 65535 matches; change `I_delay` after arming.
  - Required: `O_match_total` holds 0xFFFF; trigger timing uses the delay latched at arm.
- **Auto-rearm build (`TRACE_TRIG_SEQ_AUTOREARM_EN` defined):**
  - Stimulus: two trigger sequences with no intervening arm.
  - Required: two trigger pulses; `O_done` pulses one cycle after each; `O_armed` returns to 1.

Source files
------------

// File: rtl/trace_trigger_seq.sv
// trace_trigger_seq: counts qualifying trace-match pulses while armed, waits a
// programmable delay, then drives a trigger pulse of programmable width.
//
// Ports:
//   TRACECLK, resetn      - clock and synchronous active-low reset
//   I_matching_pattern    - per-rule one-cycle match pulses
//   I_rule_select         - rules that qualify a match (latched on arm)
//   I_match_count         - matches required, 0 acts as 1 (latched on arm)
//   I_delay               - cycles from final match to trigger (latched on arm)
//   I_pulse_width         - trigger high time, 0 acts as 1 (latched on arm)
//   I_arm, I_disarm       - single-cycle arm / abort requests (disarm wins)
//   O_trig_out            - registered trigger pulse
//   O_armed               - high while in ARMED
//   O_done                - sequence complete
//   O_match_total         - saturating count of qualifying matches
//
// Build option: define TRACE_TRIG_SEQ_AUTOREARM_EN to return to ARMED after
// each pulse (O_done then pulses for one cycle) instead of stopping in DONE.

module trace_trigger_seq #(
    parameter int pMATCH_RULES = 8,
    parameter int pCOUNT_WIDTH = 16,
    parameter int pDELAY_WIDTH = 16,
    parameter int pWIDTH_WIDTH = 8
) (
    input  logic                    TRACECLK,
    input  logic                    resetn,
    input  logic [pMATCH_RULES-1:0] I_matching_pattern,
    input  logic [pMATCH_RULES-1:0] I_rule_select,
    input  logic [pCOUNT_WIDTH-1:0] I_match_count,
    input  logic [pDELAY_WIDTH-1:0] I_delay,
    input  logic [pWIDTH_WIDTH-1:0] I_pulse_width,
    input  logic                    I_arm,
    input  logic                    I_disarm,
    output logic                    O_trig_out,
    output logic                    O_armed,
    output logic                    O_done,
    output logic [pCOUNT_WIDTH-1:0] O_match_total
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [pMATCH_RULES-1:0] sel_q, sel_d;
    logic [pCOUNT_WIDTH-1:0] thr_q, thr_d;
    logic [pDELAY_WIDTH-1:0] dly_q, dly_d;
    logic [pWIDTH_WIDTH-1:0] wid_q, wid_d;

    logic [pCOUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [pCOUNT_WIDTH-1:0] total_q, total_d;
    logic [pDELAY_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [pWIDTH_WIDTH-1:0] wcnt_q, wcnt_d;

    logic trig_q, trig_d;
    logic armed_q, armed_d;
    logic done_q, done_d;

`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
    logic rearm_q, rearm_d;
`endif

    logic                    qual;
    logic                    arm_ok;
    logic [pCOUNT_WIDTH-1:0] cnt_inc;
    logic                    pulse_end;

    always_comb begin
        qual      = |(I_matching_pattern & sel_q);
        arm_ok    = I_arm && !I_disarm;
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + pCOUNT_WIDTH'(1);
        pulse_end = 1'b0;

        state_d = state_q;
        sel_d   = sel_q;
        thr_d   = thr_q;
        dly_d   = dly_q;
        wid_d   = wid_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        dcnt_d  = dcnt_q;
        wcnt_d  = wcnt_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // Total is cleared on a new arm rather than on entry to
                // IDLE so that an abort leaves the count visible.
                if (arm_ok) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                    total_d = '0;
                    sel_d   = I_rule_select;
                    dly_d   = I_delay;
                    thr_d   = (I_match_count == '0)
                              ? pCOUNT_WIDTH'(1) : I_match_count;
                    wid_d   = (I_pulse_width == '0)
                              ? pWIDTH_WIDTH'(1) : I_pulse_width;
                end
            end
            ST_ARMED: begin
                if (qual) begin
                    cnt_d   = cnt_inc;
                    total_d = (total_q == '1)
                              ? total_q : total_q + pCOUNT_WIDTH'(1);
                    if (cnt_inc >= thr_q) begin
                        if (dly_q == '0) begin
                            state_d = ST_PULSE;
                            wcnt_d  = wid_q;
                        end else begin
                            state_d = ST_DELAY;
                            dcnt_d  = dly_q;
                        end
                    end
                end
            end
            ST_DELAY: begin
                if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - pDELAY_WIDTH'(1);
                end
                if (dcnt_q <= pDELAY_WIDTH'(1)) begin
                    state_d = ST_PULSE;
                    wcnt_d  = wid_q;
                end
            end
            ST_PULSE: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - pWIDTH_WIDTH'(1);
                end
                if (wcnt_q <= pWIDTH_WIDTH'(1)) begin
                    pulse_end = 1'b1;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
                    state_d = ST_ARMED;
                    cnt_d   = '0;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (I_disarm) begin
            state_d = ST_IDLE;
        end

        // Trigger and done lag the state by one edge so that the trigger
        // rises one cycle after the final match even with zero delay.
        armed_d = (state_d == ST_ARMED);
        trig_d  = (state_q == ST_PULSE) && !I_disarm;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
        rearm_d = pulse_end && !I_disarm;
        done_d  = rearm_q && !I_disarm;
`else
        done_d  = (state_q == ST_DONE) && (state_d == ST_DONE)
                  && !pulse_end;
`endif
    end

    always_ff @(posedge TRACECLK) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            thr_q   <= '0;
            dly_q   <= '0;
            wid_q   <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            dcnt_q  <= '0;
            wcnt_q  <= '0;
            trig_q  <= 1'b0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
            rearm_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            thr_q   <= thr_d;
            dly_q   <= dly_d;
            wid_q   <= wid_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            dcnt_q  <= dcnt_d;
            wcnt_q  <= wcnt_d;
            trig_q  <= trig_d;
            armed_q <= armed_d;
            done_q  <= done_d;
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
            rearm_q <= rearm_d;
`endif
        end
    end

    assign O_trig_out    = trig_q;
    assign O_armed       = armed_q;
    assign O_done        = done_q;
    assign O_match_total = total_q;

endmodule

// File: tb/tb_trace_trigger_seq.sv
// Directed self-checking bench for trace_trigger_seq.
// Inputs change and outputs are sampled 1ns after each rising edge.

module tb_trace_trigger_seq;

    logic        clk;
    logic        resetn;
    logic [7:0]  match;
    logic [7:0]  sel;
    logic [15:0] cnt;
    logic [15:0] dly;
    logic [7:0]  wid;
    logic        arm;
    logic        disarm;
    logic        trig;
    logic        armed;
    logic        done;
    logic [15:0] total;

    int checks = 0;
    int errors = 0;

    trace_trigger_seq dut (
        .TRACECLK           (clk),
        .resetn             (resetn),
        .I_matching_pattern (match),
        .I_rule_select      (sel),
        .I_match_count      (cnt),
        .I_delay            (dly),
        .I_pulse_width      (wid),
        .I_arm              (arm),
        .I_disarm           (disarm),
        .O_trig_out         (trig),
        .O_armed            (armed),
        .O_done             (done),
        .O_match_total      (total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [7:0] s, input logic [15:0] c,
                          input logic [15:0] d, input logic [7:0] w);
        sel = s; cnt = c; dly = d; wid = w;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; match = '0; sel = '0; cnt = '0; dly = '0;
        wid = '0; arm = 1'b0; disarm = 1'b0;
        repeat (3) tick();
        checks++;
        if ({trig, armed, done, total} !== 19'd0) begin
            errors++;
            $display("FAIL reset outs=%h exp=0", {trig, armed, done, total});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_arm(8'h01, 16'd1, 16'd0, 8'd1);
        checks++;
        if (armed !== 1'b1 || total !== 16'd0) begin
            errors++;
            $display("FAIL arm_latency armed=%b total=%0d exp 1/0", armed, total);
        end
        repeat (3) tick();
        match = 8'h01;
        tick();
        match = 8'h00;
        checks++;
        if (trig !== 1'b0 || total !== 16'd1) begin
            errors++;
            $display("FAIL basic_n trig=%b total=%0d exp 0/1", trig, total);
        end
        tick();
        checks++;
        if (trig !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_n1 trig=%b done=%b exp 1/0", trig, done);
        end
        tick();
        checks++;
        if (trig !== 1'b0 || done !== 1'b1 || total !== 16'd1) begin
            errors++;
            $display("FAIL basic_n2 trig=%b done=%b total=%0d exp 0/1/1",
                     trig, done, total);
        end
    endtask

    task automatic test_count_select_delay();
        logic [7:0] pats [5] = '{8'h01, 8'h04, 8'h01, 8'h08, 8'h0C};
        logic [15:0] tots [5] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3};
        logic et;
        logic ed;
        do_arm(8'h0C, 16'd3, 16'd5, 8'd4);
        checks++;
        if (done !== 1'b0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL rearm_from_done done=%b armed=%b exp 0/1", done, armed);
        end
        for (int i = 0; i < 5; i++) begin
            match = pats[i];
            tick();
            checks++;
            if (total !== tots[i]) begin
                errors++;
                $display("FAIL sel_count step%0d total=%0d exp %0d",
                         i, total, tots[i]);
            end
        end
        for (int j = 1; j <= 11; j++) begin
            match = (j % 2 == 1) ? 8'h0D : 8'h01;
            tick();
            et = (j >= 6 && j <= 9);
            ed = (j >= 10);
            checks++;
            if (trig !== et || done !== ed || total !== 16'd3) begin
                errors++;
                $display("FAIL delay_win N+%0d trig=%b done=%b total=%0d exp %b/%b/3",
                         j, trig, done, total, et, ed);
            end
        end
        match = 8'h00;
    endtask

    task automatic test_disarm();
        do_arm(8'h01, 16'd1, 16'd5, 8'd2);
        match = 8'h01;
        tick();
        match = 8'h00;
        repeat (2) tick();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        checks++;
        if (armed !== 1'b0 || trig !== 1'b0 || done !== 1'b0 || total !== 16'd1) begin
            errors++;
            $display("FAIL disarm armed=%b trig=%b done=%b total=%0d exp 0/0/0/1",
                     armed, trig, done, total);
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            checks++;
            if (trig !== 1'b0 || armed !== 1'b0) begin
                errors++;
                $display("FAIL disarm_quiet t%0d trig=%b armed=%b exp 0/0",
                         j, trig, armed);
            end
        end
        arm = 1'b1;
        disarm = 1'b1;
        tick();
        arm = 1'b0;
        disarm = 1'b0;
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL arm_disarm armed=%b exp 0", armed);
        end
        match = 8'h01;
        tick();
        match = 8'h00;
        tick();
        checks++;
        if (armed !== 1'b0 || trig !== 1'b0 || total !== 16'd1) begin
            errors++;
            $display("FAIL collision_idle armed=%b trig=%b total=%0d exp 0/0/1",
                     armed, trig, total);
        end
    endtask

    task automatic test_zero_settings();
        do_arm(8'h02, 16'd0, 16'd0, 8'd0);
        checks++;
        if (total !== 16'd0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL zero_arm total=%0d armed=%b exp 0/1", total, armed);
        end
        match = 8'h02;
        tick();
        match = 8'h00;
        tick();
        checks++;
        if (trig !== 1'b1 || total !== 16'd1) begin
            errors++;
            $display("FAIL zero_trig trig=%b total=%0d exp 1/1", trig, total);
        end
        tick();
        checks++;
        if (trig !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_width trig=%b done=%b exp 0/1", trig, done);
        end
    endtask

    task automatic test_saturation();
        logic et;
        do_arm(8'h80, 16'hFFFF, 16'd3, 8'd1);
        dly = 16'd10;
        wid = 8'd50;
        cnt = 16'd1;
        sel = 8'hFF;
        match = 8'h81;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (i == 65534) begin
                checks++;
                if (total !== 16'hFFFE || armed !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_pre total=%h armed=%b exp fffe/1",
                             total, armed);
                end
            end
        end
        checks++;
        if (total !== 16'hFFFF || armed !== 1'b0) begin
            errors++;
            $display("FAIL sat_final total=%h armed=%b exp ffff/0", total, armed);
        end
        for (int j = 1; j <= 6; j++) begin
            tick();
            et = (j == 4);
            checks++;
            if (trig !== et || total !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_latched N+%0d trig=%b total=%h exp %b/ffff",
                         j, trig, total, et);
            end
        end
        match = 8'h00;
    endtask

    task automatic test_autorearm();
        logic et;
        logic ea;
        logic ed;
        do_arm(8'h01, 16'd2, 16'd1, 8'd2);
        for (int s = 0; s < 2; s++) begin
            match = 8'h01;
            repeat (2) tick();
            match = 8'h00;
            for (int j = 1; j <= 5; j++) begin
                tick();
                et = (j == 2 || j == 3);
                ea = (j >= 3);
                ed = (j == 4);
                checks++;
                if (trig !== et || armed !== ea || done !== ed) begin
                    errors++;
                    $display("FAIL autorearm s%0d N+%0d trig=%b armed=%b done=%b exp %b/%b/%b",
                             s, j, trig, armed, done, et, ea, ed);
                end
            end
        end
        checks++;
        if (total !== 16'd4) begin
            errors++;
            $display("FAIL autorearm_total total=%0d exp 4", total);
        end
    endtask

    initial begin
        test_reset();
`ifdef TRACE_TRIG_SEQ_AUTOREARM_EN
        test_autorearm();
`else
        test_basic();
        test_count_select_delay();
        test_disarm();
        test_zero_settings();
        test_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
